seven_seg_display_ctrl: RTL and testbench
=========================================

// Module: seven_seg_display_ctrl
// PURPOSE
//   Sequences the 4-digit multiplexed seven-segment display from a single system clock.
//   Divides clk into a digit-scan tick and rotates a one-hot active-low anode ring.
//   Selects the active digit's nibble, hex-decodes it and drives segments and decimal point.
//   Accepts new 16-bit display values via valid/ready; applies them only at frame boundaries (no tearing).
// PARAMETERS
//   DIV_COUNT     100000  clk cycles per digit slot (>=2); 1 kHz digit rate at 100 MHz
//   BLANK_CYCLES  1000    all-off cycles at start of each slot (used only with SSD_GHOST_BLANK_EN); must be < DIV_COUNT
// PORTS
//   clk          in   1   system clock; single clock domain
//   reset_n      in   1   asynchronous, active-low reset
//   enable       in   1   1 = scan display; 0 = display dark, divider and ring held
//   value_in     in   16  four hex digits; [3:0] = digit0 (rightmost) ... [15:12] = digit3
//   dp_in        in   4   decimal points, bit i -> digit i, 1 = lit; captured with value_in
//   value_valid  in   1   value_in/dp_in valid
//   value_ready  out  1   block can accept a value
//   anode        out  4   active-low digit enables; bit i -> digit i
//   seg          out  7   active-low segments {g,f,e,d,c,b,a}
//   dp           out  1   active-low decimal point
//   frame_done   out  1   one-cycle pulse on each digit3 -> digit0 wrap
// BEHAVIOUR
//   Reset (async, immediate, also mid-frame): div_cnt=0, idx=0, anode=4'b1110, seg=decode(0)=7'b1000000,
//     dp=1, display reg=16'h0000/4'b0000, pending empty, value_ready=1, frame_done=0.
//   Divider: with enable=1, div_cnt counts 0..DIV_COUNT-1 and wraps; tick=1 when div_cnt==DIV_COUNT-1.
//   Ring: on tick, idx <= idx+1 mod 4 (0->1->2->3->0); anode = ~(4'b0001<<idx).
//   Outputs are registered: anode/seg/dp reflect the new idx in the cycle after tick (latency 1).
//   seg = hex decode of display[4*idx+:4]; dp = ~display_dp[idx].
//   Decode table (active-low, {g..a}): 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010
//     6=0000010 7=1111000 8=0000000 9=0010000 A=0001000 b=0000011 C=1000110 d=0100001 E=0000110 F=0001110.
//   Handshake: transfer when value_valid && value_ready; value is stored in pending, value_ready <= 0.
//     value_valid while value_ready=0 is ignored (no stall, no overwrite); source must hold it.
//   Commit: on tick with idx==3 (wrap), pending -> display reg, frame_done=1 for that cycle,
//     value_ready=1 from the next cycle. With no pending value, display reg unchanged; frame_done still pulses.
//   Accept and commit in the same cycle cannot occur (value_ready is low while pending is full).
//   enable=0: div_cnt held at 0, idx held, anode=4'b1111, seg=7'h7F, dp=1, frame_done=0;
//     pending commits on the next clock (dark display cannot tear). When enable returns to 1,
//     scanning resumes from the held idx with div_cnt=0.
// CONFIGURATION
//   SSD_GHOST_BLANK_EN defined: for div_cnt < BLANK_CYCLES in every slot, anode=4'b1111 (seg still
//     driven); digit enabled for div_cnt in [BLANK_CYCLES, DIV_COUNT-1]. Eliminates ghosting from segment/anode skew.
//   Not defined: anode switches directly on the tick; BLANK_CYCLES is ignored.
// STRUCTURE
//   Package ssd_pkg: DIGITS=4, SEG_W=7, ANODE_RESET=4'b1110, ANODE_OFF=4'b1111, SEG_OFF=7'h7F,
//     16-entry hex-to-segment constant table.
//   Sub-module ssd_hex_decoder: combinational nibble -> seg[6:0] lookup using the table.
//   Divider counter, ring index, pending/display registers and handshake stay in this module.
// TESTING (DIV_COUNT=4, BLANK_CYCLES=1 in the bench)
//   Reset release, enable=1 -> anode sequence 1110,1101,1011,0111,1110 with each step every 4 clks;
//     frame_done pulses once per 16 clks.
//   Load 16'h8F30, dp_in=4'b0100 mid-frame -> value_ready drops next clk; old value shown until wrap;
//     after wrap, digit0 seg=1000000, digit1 0110000, digit2 0001110 with dp=0, digit3 0000000; ready rises.
//   Hold value_valid with second value 16'h1234 while ready=0 -> ignored; accepted the cycle ready returns;
//     displayed after the following wrap.
//   enable=0 in slot 2 -> anode=1111 and seg=7F next clk, pending value commits within 1 clk;
//     enable=1 -> resumes at digit2.
//   Assert reset_n low mid-slot -> outputs return to reset values without a clock edge; pending is dropped.
//   With SSD_GHOST_BLANK_EN: anode=1111 for the first clk of each slot, then the one-hot value for 3 clks.
//     Without it: no all-off cycles.

Source files
------------

// File: rtl/ssd_pkg.sv
// ssd_pkg: shared constants and the hex-to-segment table for the seven-segment display controller.
package ssd_pkg;
   localparam int DIGITS = 4;
   localparam int SEG_W = 7;
   localparam logic [DIGITS-1:0] ANODE_RESET = 4'b1110;
   localparam logic [DIGITS-1:0] ANODE_OFF = 4'b1111;
   localparam logic [SEG_W-1:0] SEG_OFF = 7'h7F;
   // Active-low {g,f,e,d,c,b,a}, indexed by nibble value
   localparam logic [SEG_W-1:0] HEX_SEG [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };
endpackage

// File: rtl/ssd_hex_decoder.sv
// ssd_hex_decoder: combinational nibble to active-low segment lookup.
module ssd_hex_decoder
   import ssd_pkg::*;
(
   input  logic [3:0]       nibble,
   output logic [SEG_W-1:0] seg
);
   assign seg = HEX_SEG[nibble];
endmodule

// File: rtl/seven_seg_display_ctrl.sv
// seven_seg_display_ctrl: 4-digit multiplexed seven-segment scanner with tear-free value updates.
// Optional SSD_GHOST_BLANK_EN blanks the anodes for the first BLANK_CYCLES of every digit slot.
module seven_seg_display_ctrl
   import ssd_pkg::*;
#(
   parameter int DIV_COUNT    = 100000,
   parameter int BLANK_CYCLES = 1000
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              enable,
   input  logic [15:0]       value_in,
   input  logic [3:0]        dp_in,
   input  logic              value_valid,
   output logic              value_ready,
   output logic [3:0]        anode,
   output logic [SEG_W-1:0]  seg,
   output logic              dp,
   output logic              frame_done
);
   localparam int CW = $clog2(DIV_COUNT);
   logic [CW-1:0] div_cnt, div_nxt;
   logic [1:0] idx, idx_nxt;
   logic [15:0] disp, disp_nxt, pend;
   logic [3:0] disp_dp, disp_dp_nxt, pend_dp, anode_nxt;
   logic [SEG_W-1:0] seg_dec;
   logic pend_full, tick, wrap, accept, commit, blank;
   assign tick        = enable && div_cnt == CW'(DIV_COUNT - 1);
   assign wrap        = tick && idx == 2'd3;
   assign accept      = value_valid && !pend_full;
   // A dark display cannot tear, so a pending value may land immediately
   assign commit      = pend_full && (wrap || !enable);
   assign value_ready = !pend_full;
   assign frame_done  = wrap;
   always_comb begin
      div_nxt     = (!enable || tick) ? '0 : div_cnt + 1'b1;
      idx_nxt     = tick ? idx + 2'd1 : idx;
      disp_nxt    = commit ? pend : disp;
      disp_dp_nxt = commit ? pend_dp : disp_dp;
      anode_nxt   = (!enable || blank) ? ANODE_OFF : ~(4'b0001 << idx_nxt);
   end
`ifdef SSD_GHOST_BLANK_EN
   assign blank = int'(div_nxt) < BLANK_CYCLES;
`else
   assign blank = 1'b0;
`endif
   ssd_hex_decoder u_dec (
      .nibble (disp_nxt[4*idx_nxt +: 4]),
      .seg    (seg_dec)
   );
   // Outputs register the next-state view so they track idx with one cycle of latency after tick
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_cnt   <= '0;
         idx       <= '0;
         disp      <= '0;
         disp_dp   <= '0;
         pend      <= '0;
         pend_dp   <= '0;
         pend_full <= 1'b0;
         anode     <= ANODE_RESET;
         seg       <= HEX_SEG[0];
         dp        <= 1'b1;
      end else begin
         div_cnt   <= div_nxt;
         idx       <= idx_nxt;
         disp      <= disp_nxt;
         disp_dp   <= disp_dp_nxt;
         pend_full <= accept || (pend_full && !commit);
         if (accept) begin
            pend    <= value_in;
            pend_dp <= dp_in;
         end
         anode     <= anode_nxt;
         seg       <= enable ? seg_dec : SEG_OFF;
         dp        <= enable ? ~disp_dp_nxt[idx_nxt] : 1'b1;
      end
   end
endmodule

// File: tb/tb_seven_seg_display_ctrl.sv
// tb_seven_seg_display_ctrl: directed scoreboard bench for the seven-segment scan controller.
module tb_seven_seg_display_ctrl;
`ifdef SSD_GHOST_BLANK_EN
   localparam bit GHOST = 1'b1;
`else
   localparam bit GHOST = 1'b0;
`endif
   localparam logic [6:0] SEG_TBL [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };
   typedef struct {
      logic [3:0] an;
      logic [6:0] sg;
      logic       dpv;
      logic       fd;
   } exp_t;
   logic clk = 1'b0;
   logic reset_n, enable, value_valid, value_ready, dp, frame_done;
   logic [15:0] value_in;
   logic [3:0] dp_in, anode;
   logic [6:0] seg;
   int tests = 0;
   int fails = 0;
   exp_t q[$];
   always #5 clk = ~clk;
   seven_seg_display_ctrl #(.DIV_COUNT(4), .BLANK_CYCLES(1)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .enable      (enable),
      .value_in    (value_in),
      .dp_in       (dp_in),
      .value_valid (value_valid),
      .value_ready (value_ready),
      .anode       (anode),
      .seg         (seg),
      .dp          (dp),
      .frame_done  (frame_done)
   );
   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic push_raw(input logic [3:0] an, input logic [6:0] sg, input logic dpv, input logic fd);
      exp_t e;
      e.an = an; e.sg = sg; e.dpv = dpv; e.fd = fd;
      q.push_back(e);
   endtask
   task automatic push_slot(input int d, input logic [15:0] v, input logic [3:0] p, input int from);
      logic [3:0] oh;
      logic [3:0] nib;
      oh = 4'b0001 << d;
      nib = v[4*d +: 4];
      for (int k = from; k < 4; k++)
         push_raw((GHOST && k == 0) ? 4'b1111 : ~oh, SEG_TBL[nib], ~p[d], d == 3 && k == 3);
   endtask
   task automatic run(input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if (q.size() == 0) begin
            chk("scoreboard_empty", 16'd1, 16'd0);
         end else begin
            e = q.pop_front();
            chk("anode", {12'd0, anode}, {12'd0, e.an});
            chk("seg", {9'd0, seg}, {9'd0, e.sg});
            chk("dp", {15'd0, dp}, {15'd0, e.dpv});
            chk("frame_done", {15'd0, frame_done}, {15'd0, e.fd});
         end
      end
   endtask
   task automatic check_reset_outputs(input string tag);
      chk({tag, "_anode"}, {12'd0, anode}, 16'h000E);
      chk({tag, "_seg"}, {9'd0, seg}, 16'h0040);
      chk({tag, "_dp"}, {15'd0, dp}, 16'd1);
      chk({tag, "_ready"}, {15'd0, value_ready}, 16'd1);
      chk({tag, "_frame_done"}, {15'd0, frame_done}, 16'd0);
   endtask
   task automatic full_frame(input logic [15:0] v, input logic [3:0] p);
      for (int d = 0; d < 4; d++) push_slot(d, v, p, 0);
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end
   initial begin
      reset_n = 1'b0; enable = 1'b0; value_valid = 1'b0; value_in = '0; dp_in = '0;
      @(posedge clk);
      #1;
      check_reset_outputs("reset");
      reset_n = 1'b1; enable = 1'b1;
      // First frame of zeros, starting one cycle into slot 0
      push_slot(0, 16'h0000, 4'h0, 1);
      for (int d = 1; d < 4; d++) push_slot(d, 16'h0000, 4'h0, 0);
      run(15);
      push_slot(0, 16'h0000, 4'h0, 0);
      push_slot(1, 16'h0000, 4'h0, 0);
      q.pop_back(); q.pop_back();
      run(6);
      value_in = 16'h8F30; dp_in = 4'b0100; value_valid = 1'b1;
      chk("ready_before_load", {15'd0, value_ready}, 16'd1);
      push_raw(4'b1101, SEG_TBL[0], 1'b1, 1'b0);
      run(1);
      chk("ready_after_load", {15'd0, value_ready}, 16'd0);
      value_in = 16'h1234; dp_in = 4'b1010;
      push_raw(4'b1101, SEG_TBL[0], 1'b1, 1'b0);
      push_slot(2, 16'h0000, 4'h0, 0);
      push_slot(3, 16'h0000, 4'h0, 0);
      run(9);
      chk("ready_held_valid_ignored", {15'd0, value_ready}, 16'd0);
      push_slot(0, 16'h8F30, 4'b0100, 0);
      void'(q.pop_back()); void'(q.pop_back()); void'(q.pop_back());
      run(1);
      chk("ready_after_wrap", {15'd0, value_ready}, 16'd1);
      push_slot(0, 16'h8F30, 4'b0100, 1);
      void'(q.pop_back()); void'(q.pop_back());
      run(1);
      value_valid = 1'b0;
      chk("ready_second_accept", {15'd0, value_ready}, 16'd0);
      push_slot(0, 16'h8F30, 4'b0100, 2);
      for (int d = 1; d < 4; d++) push_slot(d, 16'h8F30, 4'b0100, 0);
      run(14);
      push_slot(0, 16'h1234, 4'b1010, 0);
      run(4);
      value_in = 16'hABCD; dp_in = 4'b0001; value_valid = 1'b1;
      push_raw(4'b1101, SEG_TBL[3], 1'b0, 1'b0);
      run(1);
      value_valid = 1'b0;
      chk("ready_third_accept", {15'd0, value_ready}, 16'd0);
      push_slot(1, 16'h1234, 4'b1010, 1);
      push_raw(GHOST ? 4'b1111 : 4'b1011, SEG_TBL[2], 1'b1, 1'b0);
      push_raw(4'b1011, SEG_TBL[2], 1'b1, 1'b0);
      run(5);
      enable = 1'b0;
      push_raw(4'b1111, 7'h7F, 1'b1, 1'b0);
      push_raw(4'b1111, 7'h7F, 1'b1, 1'b0);
      run(1);
      chk("ready_commit_while_dark", {15'd0, value_ready}, 16'd1);
      run(1);
      enable = 1'b1;
      push_slot(2, 16'hABCD, 4'b0001, 1);
      push_slot(3, 16'hABCD, 4'b0001, 0);
      push_slot(0, 16'hABCD, 4'b0001, 0);
      run(11);
      value_in = 16'h5555; dp_in = 4'b1111; value_valid = 1'b1;
      push_raw(GHOST ? 4'b1111 : 4'b1101, SEG_TBL[12], 1'b1, 1'b0);
      run(1);
      value_valid = 1'b0;
      push_raw(4'b1101, SEG_TBL[12], 1'b1, 1'b0);
      run(1);
      chk("ready_before_reset", {15'd0, value_ready}, 16'd0);
      #2;
      reset_n = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      push_slot(0, 16'h0000, 4'h0, 1);
      for (int d = 1; d < 4; d++) push_slot(d, 16'h0000, 4'h0, 0);
      push_slot(0, 16'h0000, 4'h0, 0);
      run(19);
      chk("ready_after_reset_frame", {15'd0, value_ready}, 16'd1);
      chk("scoreboard_drained", 16'(q.size()), 16'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
